// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end for the single-port RAM: deserialises 10-bit command words from MOSI and
// serialises read data back on MISO. SPI bits are sampled on clk, one bit per cycle.
module spi_slave_ctrl #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned TX_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int unsigned WordW = DATA_W + 2;
  localparam int unsigned CntW  = $clog2(WordW);
  localparam int unsigned WaitW = $clog2(TX_TIMEOUT + 1);
  localparam int unsigned BitW  = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0]  CntLast  = CntW'(WordW - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TX_TIMEOUT - 1);
  localparam logic [BitW-1:0]  BitsInit = BitW'(DATA_W - 1);

  typedef enum logic [2:0] {StIdle, StChkCmd, StWrite, StReadAdd, StReadData} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              word_done_q, word_done_d;
  logic [WordW-1:0]  shift_q, shift_d;
  logic [WordW-1:0]  rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rd_addr_done_q, rd_addr_done_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              miso_q, miso_d;
  logic              tx_wait_q, tx_wait_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [BitW-1:0]   bits_left_q, bits_left_d;
  logic [DATA_W-1:0] tx_load;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    word_done_d    = word_done_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_done_d = rd_addr_done_q;
    tx_shift_d     = tx_shift_q;
    miso_d         = 1'b0;
    tx_wait_d      = tx_wait_q;
    wait_cnt_d     = wait_cnt_q;
    bits_left_d    = bits_left_q;
    tx_load        = '0;

    unique case (state_q)
      StIdle: begin
        cnt_d       = '0;
        word_done_d = 1'b0;
        tx_wait_d   = 1'b0;
        bits_left_d = '0;
        if (!ss_n) state_d = StChkCmd;
      end
      StChkCmd: begin
        if (ss_n)                state_d = StIdle;
        else if (!mosi)          state_d = StWrite;
        else if (rd_addr_done_q) state_d = StReadData;
        else                     state_d = StReadAdd;
      end
      default: begin
        if (ss_n) begin
          // Abort: partial words are dropped and any read shift stops.
          state_d     = StIdle;
          tx_shift_d  = '0;
          tx_wait_d   = 1'b0;
          bits_left_d = '0;
        end else if (!word_done_q) begin
          shift_d = {shift_q[WordW-2:0], mosi};
          if (cnt_q == CntLast) begin
            word_done_d = 1'b1;
            rx_valid_d  = 1'b1;
            rx_data_d   = shift_d;
            if (state_q == StReadAdd) rd_addr_done_d = 1'b1;
            if (state_q == StReadData) begin
              rd_addr_done_d = 1'b0;
              tx_wait_d      = 1'b1;
              wait_cnt_d     = '0;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else if (state_q == StReadData && !rx_valid_q) begin
          // tx_valid is only looked at from the cycle after the strobe onwards.
          if (tx_wait_q) begin
            if (tx_valid || wait_cnt_q == WaitLast) begin
              tx_load     = tx_valid ? tx_data : '0;
              miso_d      = tx_load[DATA_W-1];
              tx_shift_d  = {tx_load[DATA_W-2:0], 1'b0};
              bits_left_d = BitsInit;
              tx_wait_d   = 1'b0;
            end else begin
              wait_cnt_d = wait_cnt_q + WaitW'(1);
            end
          end else if (bits_left_q != '0) begin
            miso_d      = tx_shift_q[DATA_W-1];
            tx_shift_d  = {tx_shift_q[DATA_W-2:0], 1'b0};
            bits_left_d = bits_left_q - BitW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      word_done_q    <= 1'b0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_done_q <= 1'b0;
      tx_shift_q     <= '0;
      miso_q         <= 1'b0;
      tx_wait_q      <= 1'b0;
      wait_cnt_q     <= '0;
      bits_left_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      word_done_q    <= word_done_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_done_q <= rd_addr_done_d;
      tx_shift_q     <= tx_shift_d;
      miso_q         <= miso_d;
      tx_wait_q      <= tx_wait_d;
      wait_cnt_q     <= wait_cnt_d;
      bits_left_q    <= bits_left_d;
    end
  end

  assign miso     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule
